fp_add_sub_param: RTL

- Parametrised IEEE-754 binary floating-point adder/subtractor. Successor to the fixed 64-bit multi-cycle adder.
- Generalised in exponent and mantissa width. Adds a subtract mode, full round-to-nearest-even, subnormal inputs and outputs, exception flags, and a valid/ready handshake on both input and output.
- Sits between operand producers and the square-root iteration datapath, which issues add/sub operations.

---
 rtl/fp_pkg.sv | 61 ++++++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_add_sub_param.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and field helpers for the parametrised floating-point adder.
// The helpers take a zero-extended word plus the field widths, so one set of
// functions serves every EXP_W/MAN_W instantiation.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic inexact;
    } fp_flags_t;

    // Widest packed word the helpers can inspect.
    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] low_mask(input int n);
        return ~({MAX_W{1'b1}} << n);
    endfunction

    function automatic logic [MAX_W-1:0] exp_field(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
        return (w >> man_w) & low_mask(exp_w);
    endfunction

    function automatic logic [MAX_W-1:0] frac_field(input logic [MAX_W-1:0] w, input int man_w);
        return w & low_mask(man_w);
    endfunction

    function automatic logic is_nan(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
        return (exp_field(w, exp_w, man_w) == low_mask(exp_w)) && (frac_field(w, man_w) != '0);
    endfunction

    // Signalling NaNs have the fraction MSB clear.
    function automatic logic is_snan(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
        return is_nan(w, exp_w, man_w) && !w[man_w-1];
    endfunction

    function automatic logic is_inf(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
        return (exp_field(w, exp_w, man_w) == low_mask(exp_w)) && (frac_field(w, man_w) == '0);
    endfunction

    function automatic logic is_zero(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
        return (exp_field(w, exp_w, man_w) == '0) && (frac_field(w, man_w) == '0);
    endfunction

    // Canonical quiet NaN: sign set, exponent all ones, fraction MSB set.
    function automatic logic [MAX_W-1:0] qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] one;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        return (one << (exp_w + man_w)) | (low_mask(exp_w) << man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports N.
module fp_lzc #(
    parameter int N  = 57,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  din,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (din[i]) count = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/fp_add_sub_param.sv
// Multi-cycle IEEE-754 adder/subtractor with RNE rounding, subnormal support,
// exception flags and valid/ready handshakes on both sides. Specials resolve
// at the start of the ALIGN cycle; the normal path finishes out of ROUND.
module fp_add_sub_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW = MAN_W + 5;          // MW plus a carry bit
    localparam int EW = EXP_W + 2;          // signed working exponent
    localparam int CW = $clog2(SW + 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    state_t                state_reg, state_next;
    logic                  in_ready_reg, in_ready_next;
    logic                  out_valid_reg, out_valid_next;
    logic [W-1:0]          result_reg, result_next;
    fp_flags_t             flags_reg, flags_next;
    logic [W-1:0]          a_reg, a_next, b_reg, b_next;
    logic                  sign_a_reg, sign_a_next, sign_b_reg, sign_b_next;
    logic signed [EW-1:0]  exp_a_reg, exp_a_next, exp_b_reg, exp_b_next;
    logic [MW-1:0]         man_a_reg, man_a_next, man_b_reg, man_b_next;
    logic [SW-1:0]         sum_reg, sum_next;
    logic signed [EW-1:0]  exp_r_reg, exp_r_next;
    logic                  sign_r_reg, sign_r_next;

    logic [MAX_W-1:0]      a_ext, b_ext;
    logic                  nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
    logic                  swap;
    logic signed [EW-1:0]  exp_diff;
    int                    shamt;
    logic [2*MW-1:0]       shifted;
    logic [SW-1:0]         sum_raw;
    logic [CW-1:0]         lz;
    int                    norm_shift;
    logic                  round_up, inexact;
    logic [MAN_W+1:0]      mant_rnd;
    logic signed [EW-1:0]  exp_rnd;

    assign a_ext  = {{(MAX_W-W){1'b0}}, a_reg};
    assign b_ext  = {{(MAX_W-W){1'b0}}, b_reg};
    assign nan_a  = is_nan(a_ext, EXP_W, MAN_W);
    assign nan_b  = is_nan(b_ext, EXP_W, MAN_W);
    assign snan_a = is_snan(a_ext, EXP_W, MAN_W);
    assign snan_b = is_snan(b_ext, EXP_W, MAN_W);
    assign inf_a  = is_inf(a_ext, EXP_W, MAN_W);
    assign inf_b  = is_inf(b_ext, EXP_W, MAN_W);
    assign zero_a = is_zero(a_ext, EXP_W, MAN_W);
    assign zero_b = is_zero(b_ext, EXP_W, MAN_W);

    fp_lzc #(.N(SW), .CW(CW)) u_lzc (
        .din   (sum_reg),
        .count (lz)
    );

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;

    // Next-state and datapath: shared arithmetic first, then the per-state updates.
    always_comb begin
        state_next     = state_reg;
        in_ready_next  = in_ready_reg;
        out_valid_next = out_valid_reg;
        result_next    = result_reg;
        flags_next     = flags_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        sign_a_next    = sign_a_reg;
        sign_b_next    = sign_b_reg;
        exp_a_next     = exp_a_reg;
        exp_b_next     = exp_b_reg;
        man_a_next     = man_a_reg;
        man_b_next     = man_b_reg;
        sum_next       = sum_reg;
        exp_r_next     = exp_r_reg;
        sign_r_next    = sign_r_reg;

        // Alignment: the larger magnitude becomes A, B is shifted with sticky collection.
        swap     = (exp_b_reg > exp_a_reg) || ((exp_b_reg == exp_a_reg) && (man_b_reg > man_a_reg));
        exp_diff = swap ? (exp_b_reg - exp_a_reg) : (exp_a_reg - exp_b_reg);
        shamt    = (exp_diff > EW'(MW)) ? MW : int'(exp_diff);
        shifted  = {(swap ? man_a_reg : man_b_reg), {MW{1'b0}}} >> shamt;

        // Magnitude add or subtract; A is never smaller than B here.
        sum_raw = (sign_a_reg == sign_b_reg) ? ({1'b0, man_a_reg} + {1'b0, man_b_reg})
                                             : ({1'b0, man_a_reg} - {1'b0, man_b_reg});

        // Left shift stops at exponent 1 so tiny results become subnormal.
        norm_shift = int'(lz) - 1;
        if (norm_shift > int'(exp_r_reg) - 1) norm_shift = int'(exp_r_reg) - 1;

        // Round to nearest even on guard and round|sticky.
        round_up = sum_reg[2] & (sum_reg[1] | sum_reg[0] | sum_reg[3]);
        inexact  = |sum_reg[2:0];
        mant_rnd = {1'b0, sum_reg[MW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        exp_rnd  = exp_r_reg;
        if (mant_rnd[MAN_W+1]) begin
            mant_rnd = mant_rnd >> 1;
            exp_rnd  = exp_r_reg + EW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    a_next        = op_a;
                    b_next        = {op_b[W-1] ^ sub, op_b[W-2:0]};
                    in_ready_next = 1'b0;
                    state_next    = UNPACK;
                end
            end
            UNPACK: begin
                sign_a_next = a_reg[W-1];
                sign_b_next = b_reg[W-1];
                exp_a_next  = (a_reg[W-2:MAN_W] == '0) ? EW'(1) : EW'(a_reg[W-2:MAN_W]);
                exp_b_next  = (b_reg[W-2:MAN_W] == '0) ? EW'(1) : EW'(b_reg[W-2:MAN_W]);
                man_a_next  = {(a_reg[W-2:MAN_W] != '0), a_reg[MAN_W-1:0], 3'b000};
                man_b_next  = {(b_reg[W-2:MAN_W] != '0), b_reg[MAN_W-1:0], 3'b000};
                state_next  = ALIGN;
            end
            ALIGN: begin
                out_valid_next = 1'b1;
                state_next     = DONE;
                flags_next     = '0;
                if (nan_a || nan_b) begin
                    result_next = W'(qnan(EXP_W, MAN_W));
                    flags_next  = '{invalid: snan_a | snan_b, overflow: 1'b0, inexact: 1'b0};
                end else if (inf_a && inf_b && (a_reg[W-1] != b_reg[W-1])) begin
                    result_next = W'(qnan(EXP_W, MAN_W));
                    flags_next  = '{invalid: 1'b1, overflow: 1'b0, inexact: 1'b0};
                end else if (inf_a) begin
                    result_next = a_reg;
                end else if (inf_b) begin
                    result_next = b_reg;
                end else if (zero_a && zero_b) begin
                    result_next = (a_reg[W-1] == b_reg[W-1]) ? a_reg : '0;
                end else if (zero_a) begin
                    result_next = b_reg;
                end else if (zero_b) begin
                    result_next = a_reg;
                end else begin
                    out_valid_next = 1'b0;
                    flags_next     = flags_reg;
                    state_next     = ADD;
                    man_a_next     = swap ? man_b_reg : man_a_reg;
                    exp_a_next     = swap ? exp_b_reg : exp_a_reg;
                    sign_a_next    = swap ? sign_b_reg : sign_a_reg;
                    sign_b_next    = swap ? sign_a_reg : sign_b_reg;
                    man_b_next     = shifted[2*MW-1:MW] | {{(MW-1){1'b0}}, |shifted[MW-1:0]};
                end
            end
            ADD: begin
                if (sum_raw == '0) begin
                    result_next    = '0;
                    flags_next     = '0;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    sum_next    = sum_raw;
                    exp_r_next  = exp_a_reg;
                    sign_r_next = sign_a_reg;
                    state_next  = NORM;
                end
            end
            NORM: begin
                if (sum_reg[SW-1]) begin
                    sum_next   = {1'b0, sum_reg[SW-1:1]} | {{(SW-1){1'b0}}, sum_reg[0]};
                    exp_r_next = exp_r_reg + EW'(1);
                end else begin
                    sum_next   = sum_reg << norm_shift;
                    exp_r_next = exp_r_reg - EW'(norm_shift);
                end
                state_next = ROUND;
            end
            ROUND: begin
                if (exp_rnd >= EXP_MAX) begin
                    result_next = {sign_r_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_next  = '{invalid: 1'b0, overflow: 1'b1, inexact: 1'b1};
                end else begin
                    result_next = {sign_r_reg, (mant_rnd[MAN_W] ? exp_rnd[EXP_W-1:0] : {EXP_W{1'b0}}),
                                   mant_rnd[MAN_W-1:0]};
                    flags_next  = '{invalid: 1'b0, overflow: 1'b0, inexact: inexact};
                end
                out_valid_next = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Handshake, result and datapath registers; reset drops any operation in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sign_a_reg    <= 1'b0;
            sign_b_reg    <= 1'b0;
            exp_a_reg     <= '0;
            exp_b_reg     <= '0;
            man_a_reg     <= '0;
            man_b_reg     <= '0;
            sum_reg       <= '0;
            exp_r_reg     <= '0;
            sign_r_reg    <= 1'b0;
        end else begin
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            flags_reg     <= flags_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            sign_a_reg    <= sign_a_next;
            sign_b_reg    <= sign_b_next;
            exp_a_reg     <= exp_a_next;
            exp_b_reg     <= exp_b_next;
            man_a_reg     <= man_a_next;
            man_b_reg     <= man_b_next;
            sum_reg       <= sum_next;
            exp_r_reg     <= exp_r_next;
            sign_r_reg    <= sign_r_next;
        end
    end

endmodule
